// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-side ordering engine.
//   - sort_state_e : controller phases (load operands, sort, drain results)
//   - DEF_W/DEF_N  : default operand width and batch size
//   - DEF_MOST_NEG / DEF_MOST_POS : extreme two's-complement values at DEF_W
//   - most_neg()/most_pos() : the same extremes for an arbitrary width (<= 16)
package alu_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } sort_state_e;

  localparam int DEF_W = 6;
  localparam int DEF_N = 4;

  localparam logic [DEF_W-1:0] DEF_MOST_NEG = {1'b1, {(DEF_W-1){1'b0}}};
  localparam logic [DEF_W-1:0] DEF_MOST_POS = {1'b0, {(DEF_W-1){1'b1}}};

  // Most-negative value of a w-bit operand, returned right-aligned in 16 bits.
  function automatic logic [15:0] most_neg(input int w);
    logic [15:0] r;
    r = 16'd0;
    r[w-1] = 1'b1;
    return r;
  endfunction

  // Most-positive value of a w-bit operand, returned right-aligned in 16 bits.
  function automatic logic [15:0] most_pos(input int w);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < w - 1; i++) begin
      r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/signed_lt.sv
// Combinational two's-complement less-than comparator.
//   a_i  : left operand (signed, W bits)
//   b_i  : right operand (signed, W bits)
//   lt_o : 1 iff a_i < b_i as signed values
module signed_lt #(
  parameter int W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         lt_o
);

  // Signed compare only; an unsigned compare would misorder the extremes.
  always_comb begin
    lt_o = 1'b0;
    if ($signed(a_i) < $signed(b_i)) begin
      lt_o = 1'b1;
    end else begin
      lt_o = 1'b0;
    end
  end

endmodule

// File: rtl/signed_sort_ctrl.sv
// Batch sorter: accepts N signed operands, bubble-sorts them in place using a
// single shared comparator (one compare per cycle), then streams them out in
// ascending signed order.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   in_valid   : in_data valid
//   in_ready   : operand accepted this cycle if in_valid (LOAD only)
//   in_data    : signed operand
//   out_valid  : out_data valid (DRAIN only)
//   out_ready  : consumer takes out_data
//   out_data   : next sorted operand
//   busy       : sort in progress
//   pass_cnt   : bubble passes completed for the current batch
module signed_sort_ctrl
  import alu_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 busy,
  output logic [$clog2(N):0]   pass_cnt
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int PCW  = $clog2(N) + 1;

  localparam logic [IDXW-1:0] IDX_LAST     = IDXW'(N - 1);
  localparam logic [IDXW-1:0] IDX_PASS_END = IDXW'(N - 2);
  localparam logic [PCW-1:0]  LAST_PASS    = PCW'(N - 1);

  sort_state_e      state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [PCW-1:0]   pass_q, pass_d;
  logic             swap_q, swap_d;
  logic [W-1:0]     mem_q [N];
  logic [W-1:0]     mem_d [N];
  logic             in_ready_q, out_valid_q, busy_q;

  logic [IDXW-1:0]  idx_nb_s;
  logic [W-1:0]     lo_s, hi_s;
  logic             lt_s;
  logic             swap_any_s;

  // Neighbour index for the compare pair; clamped so DRAIN/LOAD never form an
  // out-of-range address.
  always_comb begin
    idx_nb_s = idx_q;
    if (idx_q == IDX_LAST) begin
      idx_nb_s = idx_q;
    end else begin
      idx_nb_s = idx_q + IDXW'(1);
    end
  end

  assign lo_s = mem_q[idx_q];
  assign hi_s = mem_q[idx_nb_s];

  // Out-of-order when the upper entry is strictly smaller; equal never swaps.
  signed_lt #(.W(W)) u_lt (
    .a_i  (hi_s),
    .b_i  (lo_s),
    .lt_o (lt_s)
  );

  // Next-state computation for sequencing, array contents and pass tracking.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    swap_d     = swap_q;
    mem_d      = mem_q;
    swap_any_s = swap_q | lt_s;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_d[idx_q] = in_data;
          if (idx_q == IDX_LAST) begin
            state_d = ST_SORT;
            idx_d   = '0;
            pass_d  = '0;
            swap_d  = 1'b0;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_SORT: begin
        if (lt_s) begin
          mem_d[idx_q]    = hi_s;
          mem_d[idx_nb_s] = lo_s;
        end else begin
          mem_d = mem_q;
        end
        if (idx_q == IDX_PASS_END) begin
          pass_d = pass_q + PCW'(1);
          idx_d  = '0;
          // A clean pass proves order; N-1 passes bound the worst case.
          if (!swap_any_s || (pass_d == LAST_PASS)) begin
            state_d = ST_DRAIN;
            swap_d  = swap_any_s;
          end else begin
            swap_d = 1'b0;
          end
        end else begin
          idx_d  = idx_q + IDXW'(1);
          swap_d = swap_any_s;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  // Controller state, array and handshake flags; flags follow the next state
  // so they are registered yet aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      pass_q      <= '0;
      swap_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      swap_q      <= swap_d;
      mem_q       <= mem_d;
      in_ready_q  <= (state_d == ST_LOAD);
      out_valid_q <= (state_d == ST_DRAIN);
      busy_q      <= (state_d == ST_SORT);
    end
  end

  // Result word read straight from the array, forced to zero outside DRAIN.
  always_comb begin
    out_data = '0;
    if (out_valid_q) begin
      out_data = mem_q[idx_q];
    end else begin
      out_data = '0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign pass_cnt  = pass_q;

endmodule

// File: tb/tb_signed_sort_ctrl.sv
module tb_signed_sort_ctrl;
  import alu_pkg::*;

  localparam int W = 6;
  localparam int N = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic [2:0]    pass_cnt;

  int n_checks = 0;
  int n_errors = 0;

  signed_sort_ctrl #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .pass_cnt  (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input int a0, input int a1, input int a2, input int a3);
    int v [4];
    int w;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int i = 0; i < N; i++) begin
      w = v[i];
      in_valid = 1'b1;
      in_data  = w[W-1:0];
      check("in_ready_load", 32'(in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Waits out SORT (holding a stray in_valid), checks its length and swaps
  // in the first pass when exp_swaps >= 0.
  task automatic wait_sort(input string tag, input int exp_cycles, input int exp_swaps);
    int cyc;
    int swaps;
    cyc = 0;
    swaps = 0;
    in_valid = 1'b1;
    in_data  = 6'h15;
    while (busy && cyc < 100) begin
      if (cyc == 0) check({tag, "_in_ready_sort"}, 32'(in_ready), 32'd0);
      if (cyc < N - 1 && dut.lt_s) swaps++;
      cyc++;
      step();
    end
    in_valid = 1'b0;
    check({tag, "_sort_cycles"}, 32'(cyc), 32'(exp_cycles));
    check({tag, "_first_out_valid"}, 32'(out_valid), 32'd1);
    if (exp_swaps >= 0) check({tag, "_pass1_swaps"}, 32'(swaps), 32'(exp_swaps));
  endtask

  task automatic drain4(input string tag, input int e0, input int e1, input int e2,
                        input int e3, input int exp_pass, input bit rnd);
    int e [4];
    int got;
    int guard;
    int w;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    got = 0;
    guard = 0;
    check({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(exp_pass));
    while (got < N && guard < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        w = e[got];
        check($sformatf("%s_out%0d", tag, got), 32'(out_data), 32'(w[W-1:0]));
        got++;
      end
      guard++;
      step();
    end
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(got), 32'(N));
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    // Mixed signs with both extremes: worst case three passes.
    load4(3, -2, 31, -32);
    wait_sort("b1", 9, -1);
    drain4("b1", -32, -2, 3, 31, 3, 1'b0);

    // Already sorted: single clean pass.
    load4(0, 1, 2, 3);
    wait_sort("b2", 3, 0);
    drain4("b2", 0, 1, 2, 3, 1, 1'b0);

    // Duplicates are never exchanged: exactly two swaps in pass one.
    load4(-5, 7, -5, -1);
    wait_sort("b3", 6, 2);
    drain4("b3", -5, -5, -1, 7, 2, 1'b0);

    // Extremes must not wrap.
    load4(31, -32, 0, -1);
    wait_sort("b4", 9, 3);
    drain4("b4", -32, -1, 0, 31, 3, 1'b0);
    check("pkg_most_neg", 32'(DEF_MOST_NEG), 32'(most_neg(W)));

    // Backpressure: output holds the minimum, then random ready drains in order.
    load4(3, -2, 31, -32);
    wait_sort("b5", 9, -1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_data%0d", i), 32'(out_data), 32'(DEF_MOST_NEG));
      step();
    end
    drain4("b5", -32, -2, 3, 31, 3, 1'b1);

    // Reset on the second SORT cycle abandons the batch.
    load4(5, 4, 3, 2);
    check("rs_busy_sort1", 32'(busy), 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rs_in_ready", 32'(in_ready), 32'd1);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_pass_cnt", 32'(pass_cnt), 32'd0);
    load4(1, 0, 0, 0);
    wait_sort("b6", 6, 3);
    drain4("b6", 0, 0, 0, 1, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
